pipeline_hazard_controller: RTL and testbench



---
 rtl/pipeline_hazard_controller_pkg.sv | 44 ++++
 rtl/pipeline_hazard_controller_mem_wait_timer.sv | 71 +++++++
 rtl/pipeline_hazard_controller.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: memory wait FSM encoding, register-zero constant
// and the control bundles used by the stall/flush logic.
package pipeline_hazard_controller_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_write;
        logic memwb_bubble;
    } hazard_ctrl_t;

    // Free-running pipeline: every register loads, nothing is squashed.
    localparam hazard_ctrl_t CTRL_RUN = '{
        pc_write:     1'b1,
        ifid_write:   1'b1,
        ifid_flush:   1'b0,
        idex_write:   1'b1,
        idex_flush:   1'b0,
        exmem_write:  1'b1,
        memwb_bubble: 1'b0
    };

    // Frozen pipeline filled with NOPs/bubbles, used while in reset.
    localparam hazard_ctrl_t CTRL_BUBBLE = '{
        pc_write:     1'b0,
        ifid_write:   1'b0,
        ifid_flush:   1'b1,
        idex_write:   1'b0,
        idex_flush:   1'b1,
        exmem_write:  1'b0,
        memwb_bubble: 1'b1
    };

endpackage

// File: rtl/pipeline_hazard_controller_mem_wait_timer.sv
// Wait-state sequencer for multi-cycle data-memory accesses: holds the MEM
// stage for MEM_LATENCY-1 cycles per access, re-arming from RUN each time.
module mem_wait_timer
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic memreq,
    output logic MemStall
);

    localparam int WCNT_W      = $clog2(MEM_LATENCY) + 1;
    localparam int WAIT_INIT_I = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_INIT_I);
    localparam logic HAS_WAIT = (MEM_LATENCY > 1);

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_stall_s;

    // Next-state and stall decode; memory is being reset alongside, so no stall in reset.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mem_stall_s = 1'b0;
        case (state_q)
            RUN: begin
                if (memreq && HAS_WAIT) begin
                    mem_stall_s = 1'b1;
                    state_d     = MEM_WAIT;
                    wcnt_d      = WAIT_INIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (wcnt_q != WCNT_W'(0)) begin
                    mem_stall_s = 1'b1;
                    wcnt_d      = wcnt_q - WCNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = WCNT_W'(0);
            end
        endcase
        if (Reset) begin
            mem_stall_s = 1'b0;
        end else begin
            mem_stall_s = mem_stall_s;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= RUN;
            wcnt_q  <= WCNT_W'(0);
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign MemStall = mem_stall_s;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritises memory
// wait states, taken branches and load-use hazards, and keeps statistics.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             R_Enable_EX,
    input  logic [4:0]       rDest_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             UsesRs_ID,
    input  logic             UsesRt_ID,
    input  logic             Branch_Taken_EX,
    input  logic             R_Enable_MEM,
    input  logic             W_Enable_MEM,
    input  logic             Stat_Clear,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Flush,
    output logic             EXMEM_Write,
    output logic             MEMWB_Bubble,
    output logic             MemStall,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_W'(1));
    endfunction

    logic             memreq_s;
    logic             mem_stall_s;
    logic             load_use_s;
    logic             stall_event_s;
    logic             flush_event_s;
    hazard_ctrl_t     ctrl_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign memreq_s = R_Enable_MEM | W_Enable_MEM;

    mem_wait_timer #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_mem_wait_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .memreq   (memreq_s),
        .MemStall (mem_stall_s)
    );

    assign load_use_s = R_Enable_EX && (rDest_EX != REG_ZERO) &&
                        ((UsesRs_ID && (rs_ID == rDest_EX)) ||
                         (UsesRt_ID && (rt_ID == rDest_EX)));

    // Only hazards that actually take effect are counted; a branch squashes the load-use.
    assign stall_event_s = !Reset && (mem_stall_s || (!Branch_Taken_EX && load_use_s));
    assign flush_event_s = !Reset && !mem_stall_s && Branch_Taken_EX;

    // Hazard priority: reset, memory wait, taken branch, load-use.
    always_comb begin
        ctrl_s = CTRL_RUN;
        if (Reset) begin
            ctrl_s = CTRL_BUBBLE;
        end else if (mem_stall_s) begin
            ctrl_s.pc_write     = 1'b0;
            ctrl_s.ifid_write   = 1'b0;
            ctrl_s.idex_write   = 1'b0;
            ctrl_s.exmem_write  = 1'b0;
            ctrl_s.memwb_bubble = 1'b1;
        end else if (Branch_Taken_EX) begin
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
        end else if (load_use_s) begin
            ctrl_s.pc_write   = 1'b0;
            ctrl_s.ifid_write = 1'b0;
            ctrl_s.idex_flush = 1'b1;
        end else begin
            ctrl_s = CTRL_RUN;
        end
    end

    // Statistics next values: clear beats increment, counters saturate.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stat_Clear) begin
            stall_cnt_d = CNT_W'(0);
            flush_cnt_d = CNT_W'(0);
        end else begin
            if (stall_event_s) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (flush_event_s) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt_q <= CNT_W'(0);
            flush_cnt_q <= CNT_W'(0);
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_Write     = ctrl_s.pc_write;
    assign IFID_Write   = ctrl_s.ifid_write;
    assign IFID_Flush   = ctrl_s.ifid_flush;
    assign IDEX_Write   = ctrl_s.idex_write;
    assign IDEX_Flush   = ctrl_s.idex_flush;
    assign EXMEM_Write  = ctrl_s.exmem_write;
    assign MEMWB_Bubble = ctrl_s.memwb_bubble;
    assign MemStall     = mem_stall_s;
    assign StallCycles  = stall_cnt_q;
    assign FlushCount   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios then random traffic, all compared
// against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;

    localparam int L    = 3;
    localparam int W    = 5;
    localparam int MAXC = (1 << W) - 1;

    logic         Clock = 1'b0;
    logic         Reset, R_Enable_EX, UsesRs_ID, UsesRt_ID, Branch_Taken_EX;
    logic         R_Enable_MEM, W_Enable_MEM, Stat_Clear;
    logic [4:0]   rDest_EX, rs_ID, rt_ID;
    logic         PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush;
    logic         EXMEM_Write, MEMWB_Bubble, MemStall;
    logic [W-1:0] StallCycles, FlushCount;

    int tests = 0;
    int fails = 0;
    int m_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 Clock = ~Clock;

    pipeline_hazard_controller #(.MEM_LATENCY(L), .CNT_W(W)) dut (
        .Clock(Clock), .Reset(Reset), .R_Enable_EX(R_Enable_EX), .rDest_EX(rDest_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
        .Branch_Taken_EX(Branch_Taken_EX), .R_Enable_MEM(R_Enable_MEM),
        .W_Enable_MEM(W_Enable_MEM), .Stat_Clear(Stat_Clear), .PC_Write(PC_Write),
        .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .IDEX_Write(IDEX_Write),
        .IDEX_Flush(IDEX_Flush), .EXMEM_Write(EXMEM_Write), .MEMWB_Bubble(MEMWB_Bubble),
        .MemStall(MemStall), .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ren, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic br, input logic rm, input logic wm,
                         input logic clr);
        Reset = rst; R_Enable_EX = ren; rDest_EX = rd; rs_ID = rs; rt_ID = rt;
        UsesRs_ID = urs; UsesRt_ID = urt; Branch_Taken_EX = br;
        R_Enable_MEM = rm; W_Enable_MEM = wm; Stat_Clear = clr;
    endtask

    // One clock: check controls mid-cycle, advance the model, check statistics.
    // Model: an access owns MEM for L cycles; all but the last one stall.
    task automatic cycle();
        int         eff;
        logic       ms, lu, stall_ev, flush_ev;
        logic [7:0] exp, obs;
        #1;
        eff = (m_left == 0 && (R_Enable_MEM || W_Enable_MEM)) ? L : m_left;
        ms  = !Reset && (eff > 1);
        lu  = R_Enable_EX && (rDest_EX != 5'd0) &&
              ((UsesRs_ID && rs_ID == rDest_EX) || (UsesRt_ID && rt_ID == rDest_EX));
        if (Reset) begin
            exp = 8'b0010_1010;
        end else if (ms) begin
            exp = 8'b0000_0011;
        end else if (Branch_Taken_EX) begin
            exp = 8'b1111_1100;
        end else if (lu) begin
            exp = 8'b0001_1100;
        end else begin
            exp = 8'b1101_0100;
        end
        obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
               EXMEM_Write, MEMWB_Bubble, MemStall};
        chk("ctrl", {24'd0, obs}, {24'd0, exp});
        stall_ev = ms || (!Branch_Taken_EX && lu);
        flush_ev = !ms && Branch_Taken_EX;
        @(posedge Clock);
        if (Reset) begin
            m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_left = (eff > 0) ? eff - 1 : 0;
            if (Stat_Clear) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (stall_ev && m_stall < MAXC) m_stall++;
                if (flush_ev && m_flush < MAXC) m_flush++;
            end
        end
        #1;
        chk("stall_cnt", 32'(StallCycles), 32'(m_stall));
        chk("flush_cnt", 32'(FlushCount), 32'(m_flush));
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(); cycle();
        chk("reset_stall_cnt", 32'(StallCycles), 32'd0);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        // lw $t1 in EX, ID reads $t1 through rs
        drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("lu_stall_cnt", 32'(StallCycles), 32'd1);
        drive(1'b0, 1'b0, 5'd9, 5'd9, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        // $zero destination never stalls
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("zero_no_stall", {31'd0, PC_Write}, 32'd1);
        // sw in MEM: two wait cycles then advance
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(); cycle(); cycle();
        chk("sw_stall_cnt", 32'(StallCycles), 32'd3);
        // branch wins over a coincident load-use
        drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("br_lu_flush_cnt", 32'(FlushCount), 32'd1);
        // branch held during a lw wait: flushes once, on the advance cycle
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(); cycle();
        chk("br_wait_flush_cnt", 32'(FlushCount), 32'd1);
        cycle();
        chk("br_after_wait_flush_cnt", 32'(FlushCount), 32'd2);
        // reset in the middle of a wait
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("post_reset_memstall", {31'd0, MemStall}, 32'd0);
        chk("post_reset_flush_cnt", 32'(FlushCount), 32'd0);
        // saturation of both counters, then clear racing an increment
        for (int i = 0; i < MAXC + 4; i++) begin
            drive(1'b0, 1'b1, 5'd3, 5'd7, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle();
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        chk("sat_stall_cnt", 32'(StallCycles), 32'(MAXC));
        chk("sat_flush_cnt", 32'(FlushCount), 32'(MAXC));
        drive(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        chk("clear_stall_cnt", 32'(StallCycles), 32'd0);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
